// File: rtl/fb_write_arbiter.sv
// N-channel framebuffer write arbiter: per-producer FIFOs merged round-robin onto one registered port.
// Optional build macro FBARB_PRIORITY_EN makes channel 0 strict priority over the round-robin group.
`timescale 1ns/1ps

module fb_write_arbiter #(
  parameter int N_CH       = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          in_we,
  input  logic [N_CH*ADDR_W-1:0]   in_addr,
  input  logic [N_CH*DATA_W-1:0]   in_wdata,
  output logic [N_CH-1:0]          in_ready,
  input  logic                     fb_stall,
  output logic                     fb_we,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [DATA_W-1:0]        fb_wdata,
  output logic [N_CH-1:0]          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

`ifdef FBARB_PRIORITY_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  logic [ENT_W-1:0] mem    [N_CH][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [N_CH];
  logic [PTR_W-1:0] rd_ptr [N_CH];
  logic [CNT_W-1:0] count  [N_CH];

  logic [N_CH-1:0]  empty;
  logic [N_CH-1:0]  full;
  logic [N_CH-1:0]  push;
  logic [N_CH-1:0]  pop;
  logic [N_CH-1:0]  drop;

  logic [CH_W-1:0]  rr;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  scan;
  int               scan_sum;
  logic             found;
  logic             grant_valid;
  logic [ENT_W-1:0] head;

  // Status comes from the registered count only, so a same-cycle pop never re-opens a full FIFO.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      empty[c] = (count[c] == '0);
      full[c]  = (count[c] == CNT_FULL);
    end
  end

  assign in_ready = ~full;
  assign push     = in_we & ~full;
  assign drop     = in_we & full;

  // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan     = '0;
    scan_sum = 0;
    if (PRIO_EN && !empty[0]) begin
      found = 1'b1;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        scan_sum = int'(rr) + i;
        if (scan_sum >= N_CH) scan_sum = scan_sum - N_CH;
        scan = CH_W'(scan_sum);
        if (!found && !empty[scan] && !(PRIO_EN && scan == '0)) begin
          found = 1'b1;
          grant = scan;
        end
      end
    end
  end

  assign grant_valid = found && !fb_stall;
  assign pop         = grant_valid ? (N_CH'(1) << grant) : '0;
  assign head        = mem[grant][rd_ptr[grant]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      overflow <= '0;
      rr       <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + CNT_W'(1);
          2'b01:   count[c] <= count[c] - CNT_W'(1);
          default: count[c] <= count[c];
        endcase
      end
      overflow <= overflow | drop;
      // The priority channel never advances the pointer of the round-robin group.
      if (grant_valid && !(PRIO_EN && grant == '0)) begin
        rr <= (grant == LAST_CH) ? '0 : grant + CH_W'(1);
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; pointers and counts alone define validity.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= {in_addr[c*ADDR_W +: ADDR_W], in_wdata[c*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else if (grant_valid) begin
      fb_we    <= 1'b1;
      fb_addr  <= head[ENT_W-1 -: ADDR_W];
      fb_wdata <= head[DATA_W-1:0];
    end else begin
      fb_we    <= 1'b0;
    end
  end

endmodule
